// File: rtl/kernel_mem_pkg.sv
// kernel_mem_pkg: shared state encoding and constants for the kernel memory sequencer
package kernel_mem_pkg;
  localparam int MEM_ADDR_W = 64;
  localparam int BYTE_SHIFT = 2;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    STEP   = 4'd1,
    SAMPLE = 4'd2,
    ISSUE0 = 4'd3,
    WAIT0  = 4'd4,
    ISSUE1 = 4'd5,
    WAIT1  = 4'd6,
    DONE   = 4'd7,
    HALT   = 4'd8
  } state_t;
endpackage

// File: rtl/mem_txn_port.sv
// mem_txn_port: one external transaction -- byte address, enable pulse, ready wait and timeout
module mem_txn_port
  import kernel_mem_pkg::*;
#(
  parameter int ADDR_WID    = 14,
  parameter int DATA_WID    = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  waiting,
  input  logic                  is_write,
  input  logic [ADDR_WID-1:0]   addr,
  input  logic [DATA_WID-1:0]   wdata,
  input  logic [MEM_ADDR_W-1:0] read_base,
  input  logic [MEM_ADDR_W-1:0] write_base,
  input  logic [MEM_ADDR_W-1:0] size,
  input  logic                  read_ready,
  input  logic                  write_ready,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [MEM_ADDR_W-1:0] read_addr,
  output logic [MEM_ADDR_W-1:0] read_size_output,
  output logic [MEM_ADDR_W-1:0] write_addr,
  output logic [MEM_ADDR_W-1:0] write_size,
  output logic [DATA_WID-1:0]   write_data,
  output logic                  ready_hit,
  output logic                  timeout
);
  logic [MEM_ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_size_q, rd_size_d;
  logic [MEM_ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_size_q, wr_size_d, offset;
  logic [DATA_WID-1:0]   wr_data_q, wr_data_d;
  logic [31:0]           wait_cnt_q, wait_cnt_d;
  logic                  rd_issue, wr_issue;
  // The issue cycle drives freshly computed values so the enable pulse and its address coincide
  always_comb begin
    offset           = MEM_ADDR_W'(addr) << BYTE_SHIFT;
    rd_issue         = issue & ~is_write;
    wr_issue         = issue & is_write;
    rd_addr_d        = rd_issue ? read_base + offset : rd_addr_q;
    rd_size_d        = rd_issue ? size : rd_size_q;
    wr_addr_d        = wr_issue ? write_base + offset : wr_addr_q;
    wr_size_d        = wr_issue ? size : wr_size_q;
    wr_data_d        = wr_issue ? wdata : wr_data_q;
    ready_hit        = waiting & (is_write ? write_ready : read_ready);
    timeout          = waiting & ~ready_hit & (wait_cnt_q == 32'(TIMEOUT_CYC - 1));
    wait_cnt_d       = issue ? '0 : (waiting & ~ready_hit) ? wait_cnt_q + 32'd1 : wait_cnt_q;
    read_enable      = rd_issue;
    write_enable     = wr_issue;
    read_addr        = rd_addr_d;
    read_size_output = rd_size_d;
    write_addr       = wr_addr_d;
    write_size       = wr_size_d;
    write_data       = wr_data_d;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      wr_data_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_data_q  <= wr_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
endmodule

// File: rtl/kernel_mem_sequencer.sv
// kernel_mem_sequencer: steps a two-port HLS kernel by clock enable and serialises its
// BRAM-style accesses onto one external read/write memory interface
module kernel_mem_sequencer
  import kernel_mem_pkg::*;
#(
  parameter int ADDR_WID    = 14,
  parameter int DATA_WID    = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] read_base,
  input  logic [MEM_ADDR_W-1:0] write_base,
  input  logic [MEM_ADDR_W-1:0] read_size_input,
  output logic                  k_step,
  input  logic                  k_done,
  input  logic [ADDR_WID-1:0]   k_address0,
  input  logic [ADDR_WID-1:0]   k_address1,
  input  logic                  k_ce0,
  input  logic                  k_ce1,
  input  logic                  k_we0,
  input  logic                  k_we1,
  input  logic [DATA_WID-1:0]   k_d0,
  input  logic [DATA_WID-1:0]   k_d1,
  output logic [DATA_WID-1:0]   k_q0,
  output logic [DATA_WID-1:0]   k_q1,
  output logic                  read_enable,
  output logic [MEM_ADDR_W-1:0] read_addr,
  output logic [MEM_ADDR_W-1:0] read_size_output,
  input  logic                  read_ready,
  input  logic [DATA_WID-1:0]   read_data,
  output logic                  write_enable,
  output logic [MEM_ADDR_W-1:0] write_addr,
  output logic [MEM_ADDR_W-1:0] write_size,
  output logic [DATA_WID-1:0]   write_data,
  input  logic                  write_ready,
  output logic                  done,
  output logic                  err_timeout,
  output logic [31:0]           access_cnt
);
  state_t                state_q, state_d;
  logic                  ce0_q, ce0_d, ce1_q, ce1_d, we0_q, we0_d, we1_q, we1_d, kd_q, kd_d;
  logic [ADDR_WID-1:0]   a0_q, a0_d, a1_q, a1_d;
  logic [DATA_WID-1:0]   d0_q, d0_d, d1_q, d1_d, q0_q, q0_d, q1_q, q1_d;
  logic                  err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  on1, issue, waiting, ready_hit, timeout;
  assign on1     = (state_q == ISSUE1) || (state_q == WAIT1);
  assign issue   = (state_q == ISSUE0) || (state_q == ISSUE1);
  assign waiting = (state_q == WAIT0) || (state_q == WAIT1);
  mem_txn_port #(.ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID), .TIMEOUT_CYC(TIMEOUT_CYC)) u_txn (
    .clk(clk), .reset(reset), .issue(issue), .waiting(waiting),
    .is_write(on1 ? we1_q : we0_q), .addr(on1 ? a1_q : a0_q), .wdata(on1 ? d1_q : d0_q),
    .read_base(read_base), .write_base(write_base), .size(read_size_input),
    .read_ready(read_ready), .write_ready(write_ready),
    .read_enable(read_enable), .write_enable(write_enable),
    .read_addr(read_addr), .read_size_output(read_size_output),
    .write_addr(write_addr), .write_size(write_size), .write_data(write_data),
    .ready_hit(ready_hit), .timeout(timeout)
  );
  always_comb begin
    state_d = state_q;
    {ce0_d, ce1_d, we0_d, we1_d, kd_d} = {ce0_q, ce1_q, we0_q, we1_q, kd_q};
    {a0_d, a1_d, d0_d, d1_d} = {a0_q, a1_q, d0_q, d1_q};
    case (state_q)
      IDLE:   state_d = start ? STEP : IDLE;
      STEP:   state_d = SAMPLE;
      SAMPLE: begin
        {ce0_d, ce1_d, we0_d, we1_d, kd_d} = {k_ce0, k_ce1, k_we0, k_we1, k_done};
        {a0_d, a1_d, d0_d, d1_d} = {k_address0, k_address1, k_d0, k_d1};
        state_d = k_ce0 ? ISSUE0 : k_ce1 ? ISSUE1 : k_done ? DONE : STEP;
      end
      ISSUE0: state_d = WAIT0;
      ISSUE1: state_d = WAIT1;
      WAIT0:  state_d = timeout ? HALT : !ready_hit ? WAIT0 : ce1_q ? ISSUE1 : kd_q ? DONE : STEP;
      WAIT1:  state_d = timeout ? HALT : !ready_hit ? WAIT1 : kd_q ? DONE : STEP;
      DONE:   state_d = start ? DONE : IDLE;
      default: state_d = state_q;
    endcase
    q0_d  = (state_q == WAIT0 && ready_hit && !we0_q) ? read_data : q0_q;
    q1_d  = (state_q == WAIT1 && ready_hit && !we1_q) ? read_data : q1_q;
    err_d = err_q | timeout;
    cnt_d = (ready_hit && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      {ce0_q, ce1_q, we0_q, we1_q, kd_q} <= '0;
      {a0_q, a1_q, d0_q, d1_q} <= '0;
      q0_q  <= '0;
      q1_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      {ce0_q, ce1_q, we0_q, we1_q, kd_q} <= {ce0_d, ce1_d, we0_d, we1_d, kd_d};
      {a0_q, a1_q, d0_q, d1_q} <= {a0_d, a1_d, d0_d, d1_d};
      q0_q  <= q0_d;
      q1_q  <= q1_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign k_step      = state_q == STEP;
  assign done        = state_q == DONE;
  assign k_q0        = q0_q;
  assign k_q1        = q1_q;
  assign err_timeout = err_q;
  assign access_cnt  = cnt_q;
endmodule

// File: tb/tb_kernel_mem_sequencer.sv
// tb_kernel_mem_sequencer: scoreboard bench with a scripted kernel and a latency-controlled memory
module tb_kernel_mem_sequencer;
  localparam int AW = 14, DW = 32, TO = 16;
  logic clk = 0, reset = 0, start = 0;
  logic [63:0] read_base = 0, write_base = 0, read_size_input = 0;
  logic k_step, k_done = 0, k_ce0 = 0, k_ce1 = 0, k_we0 = 0, k_we1 = 0;
  logic [AW-1:0] k_address0 = 0, k_address1 = 0;
  logic [DW-1:0] k_d0 = 0, k_d1 = 0, k_q0, k_q1;
  logic read_enable, write_enable, read_ready = 0, write_ready = 0;
  logic [63:0] read_addr, read_size_output, write_addr, write_size;
  logic [DW-1:0] read_data = 0, write_data;
  logic done, err_timeout;
  logic [31:0] access_cnt;
  int errors = 0, checks = 0, nsteps = 0, txns = 0, lat = 0;
  bit hang = 0;

  typedef struct packed {
    logic ce0, we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic ce1, we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic kd;
  } kstep_t;
  typedef struct packed {logic w; logic port; logic [63:0] addr; logic [63:0] size; logic [DW-1:0] data;} txn_t;
  kstep_t prog[$];
  txn_t exp_q[$];
  logic [DW-1:0] mem[logic [63:0]];
  logic [DW-1:0] pre[logic [63:0]];
  logic [DW-1:0] sh[logic [63:0]];

  kernel_mem_sequencer #(.ADDR_WID(AW), .DATA_WID(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .read_base(read_base), .write_base(write_base),
    .read_size_input(read_size_input), .k_step(k_step), .k_done(k_done),
    .k_address0(k_address0), .k_address1(k_address1), .k_ce0(k_ce0), .k_ce1(k_ce1),
    .k_we0(k_we0), .k_we1(k_we1), .k_d0(k_d0), .k_d1(k_d1), .k_q0(k_q0), .k_q1(k_q1),
    .read_enable(read_enable), .read_addr(read_addr), .read_size_output(read_size_output),
    .read_ready(read_ready), .read_data(read_data), .write_enable(write_enable),
    .write_addr(write_addr), .write_size(write_size), .write_data(write_data),
    .write_ready(write_ready), .done(done), .err_timeout(err_timeout), .access_cnt(access_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic kstep_t mk(input int ce0, we0, a0, d0, ce1, we1, a1, d1, kd);
    return {1'(ce0), 1'(we0), AW'(a0), DW'(d0), 1'(ce1), 1'(we1), AW'(a1), DW'(d1), 1'(kd)};
  endfunction

  // Expected transactions in issue order; read entries carry the value the kernel should receive
  task automatic push_exp(input logic w, input logic port, input logic [63:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.w = w; t.port = port; t.addr = a; t.size = read_size_input;
    if (w) begin
      t.data = d;
      sh[a] = d;
    end else t.data = sh.exists(a) ? sh[a] : pre.exists(a) ? pre[a] : init_val(a);
    exp_q.push_back(t);
  endtask

  kstep_t ks;
  always @(negedge clk) if (k_step) begin
    nsteps++;
    ks = '0;
    if (prog.size() != 0) ks = prog.pop_front();
    {k_ce0, k_we0, k_address0, k_d0, k_ce1, k_we1, k_address1, k_d1, k_done} = ks;
  end

  txn_t e, pe;
  bit pend = 0, qchk = 0, got;
  int cnt = 0;
  logic [63:0] oa, os;
  always @(negedge clk) begin
    if (qchk) begin
      qchk = 0;
      checks++;
      if ((pe.port ? k_q1 : k_q0) !== pe.data) begin
        errors++;
        $display("FAIL read_q%0d addr=%h got=%h want=%h", pe.port, pe.addr, pe.port ? k_q1 : k_q0, pe.data);
      end
    end
    read_ready = 0;
    write_ready = 0;
    if (!reset) begin
      pend = 0;
      qchk = 0;
      mem.delete();
    end else if (pend && !hang) begin
      if (cnt <= 1) begin
        pend = 0;
        if (pe.w) write_ready = 1;
        else begin
          read_ready = 1;
          read_data = mem.exists(pe.addr) ? mem[pe.addr] : pre.exists(pe.addr) ? pre[pe.addr] : init_val(pe.addr);
          qchk = 1;
        end
      end else cnt--;
    end
    if (read_enable || write_enable) begin
      txns++;
      checks++;
      oa = write_enable ? write_addr : read_addr;
      os = write_enable ? write_size : read_size_output;
      got = exp_q.size() != 0;
      e = '0;
      if (got) e = exp_q.pop_front();
      if (!got || (read_enable && write_enable) || write_enable !== e.w || oa !== e.addr || os !== e.size ||
          (e.w && write_data !== e.data)) begin
        errors++;
        $display("FAIL txn got re=%b we=%b addr=%h size=%h data=%h want queued=%b w=%b addr=%h size=%h data=%h",
                 read_enable, write_enable, oa, os, write_data, got, e.w, e.addr, e.size, e.data);
      end
      if (write_enable) mem[write_addr] = write_data;
      pe = e;
      pe.addr = oa;
      pe.w = write_enable;
      cnt = lat < 0 ? int'($urandom_range(0, 3)) : lat;
      pend = 1;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    reset = 0; start = 0; hang = 0; lat = 0;
    prog.delete(); exp_q.delete(); sh.delete(); pre.delete();
    read_base = '0; write_base = '0; read_size_input = '0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done || err_timeout) ok = 1;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({k_step, read_enable, write_enable, done, err_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000", {k_step, read_enable, write_enable, done, err_timeout});
    end
    checks++;
    if (access_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", access_cnt); end
    checks++;
    if ({k_q0, k_q1} !== '0) begin errors++; $display("FAIL reset_q got=%h/%h want=0/0", k_q0, k_q1); end
    checks++;
    if ({read_addr, write_addr, read_size_output, write_size, write_data} !== '0) begin
      errors++; $display("FAIL reset_bus got ra=%h wa=%h want 0", read_addr, write_addr);
    end
  endtask

  task automatic test_no_access;
    bit ok;
    int s0;
    do_reset;
    s0 = nsteps;
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    start = 1;
    wait_done(100, ok);
    checks++;
    if (!ok || !done) begin errors++; $display("FAIL noacc_done got=%b want=1", done); end
    checks++;
    if (nsteps - s0 != 3) begin errors++; $display("FAIL noacc_steps got=%0d want=3", nsteps - s0); end
    checks++;
    if (access_cnt !== 32'd0) begin errors++; $display("FAIL noacc_cnt got=%0d want=0", access_cnt); end
  endtask

  task automatic test_done_handshake;
    int s0 = nsteps;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || nsteps != s0) begin
      errors++; $display("FAIL done_hold got done=%b steps=%0d want done=1 steps=0", done, nsteps - s0);
    end
    start = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear got=%b want=0", done); end
  endtask

  task automatic test_read_port0;
    bit ok;
    int t0;
    do_reset;
    t0 = txns;
    read_base = 64'h1000; read_size_input = 64'h40; lat = 3;
    pre[64'h1014] = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 64'h1014, '0);
    prog.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 1));
    start = 1;
    wait_done(100, ok);
    start = 0;
    @(negedge clk);
    checks++;
    if (!ok || k_q0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_q got=%h want=deadbeef", k_q0); end
    checks++;
    if (access_cnt !== 32'd1 || txns - t0 != 1) begin
      errors++; $display("FAIL rd0_cnt got=%0d/%0d want=1/1", access_cnt, txns - t0);
    end
  endtask

  task automatic test_dual;
    bit ok;
    do_reset;
    write_base = 64'h2000; read_base = 64'h3000; read_size_input = 64'h4; lat = 1;
    pre[64'h3008] = 32'hCAFE0001;
    push_exp(1'b1, 1'b0, 64'h201C, 32'h11);
    push_exp(1'b0, 1'b1, 64'h3008, '0);
    prog.push_back(mk(1, 1, 7, 32'h11, 1, 0, 2, 0, 1));
    start = 1;
    wait_done(100, ok);
    start = 0;
    @(negedge clk);
    checks++;
    if (!ok || k_q1 !== 32'hCAFE0001 || k_q0 !== 32'd0) begin
      errors++; $display("FAIL dual_q got=%h/%h want=00000000/cafe0001", k_q0, k_q1);
    end
    checks++;
    if (access_cnt !== 32'd2 || exp_q.size() != 0) begin
      errors++; $display("FAIL dual_cnt got=%0d left=%0d want=2 left=0", access_cnt, exp_q.size());
    end
  endtask

  task automatic test_same_addr;
    bit ok;
    do_reset;
    read_base = 64'h4000; write_base = 64'h4000; read_size_input = 64'h8; lat = 2;
    push_exp(1'b1, 1'b0, 64'h400C, 32'h55);
    push_exp(1'b0, 1'b1, 64'h400C, '0);
    prog.push_back(mk(1, 1, 3, 32'h55, 1, 0, 3, 0, 1));
    start = 1;
    wait_done(100, ok);
    start = 0;
    @(negedge clk);
    checks++;
    if (!ok || k_q1 !== 32'h55) begin errors++; $display("FAIL same_addr_q1 got=%h want=00000055", k_q1); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int s0, nacc = 0;
    kstep_t s;
    do_reset;
    s0 = nsteps;
    read_base = 64'h8000; write_base = 64'h8000; read_size_input = 64'd16; lat = -1;
    for (int i = 0; i < 8; i++) begin
      s = '0;
      s.ce0 = 1'($urandom_range(0, 1)); s.we0 = 1'($urandom_range(0, 1));
      s.a0 = AW'($urandom_range(0, 7)); s.d0 = $urandom;
      s.ce1 = 1'($urandom_range(0, 1)); s.we1 = 1'($urandom_range(0, 1));
      s.a1 = AW'($urandom_range(0, 7)); s.d1 = $urandom;
      s.kd = (i == 7);
      prog.push_back(s);
      if (s.ce0) begin push_exp(s.we0, 1'b0, 64'h8000 + 64'(s.a0) * 4, s.d0); nacc++; end
      if (s.ce1) begin push_exp(s.we1, 1'b1, 64'h8000 + 64'(s.a1) * 4, s.d1); nacc++; end
    end
    start = 1;
    wait_done(400, ok);
    start = 0;
    @(negedge clk);
    checks++;
    if (!ok || nsteps - s0 != 8) begin errors++; $display("FAIL b2b_steps got=%0d want=8", nsteps - s0); end
    checks++;
    if (access_cnt !== 32'(nacc) || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_cnt got=%0d left=%0d want=%0d left=0", access_cnt, exp_q.size(), nacc);
    end
  endtask

  task automatic test_timeout;
    int n = 0, s0;
    bit seen = 0, stray = 0;
    do_reset;
    hang = 1;
    push_exp(1'b0, 1'b0, 64'h4, '0);
    prog.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    start = 1;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = read_enable; end
    for (int i = 0; i < 100 && !err_timeout; i++) begin @(negedge clk); n++; end
    checks++;
    if (!seen || err_timeout !== 1'b1 || n != TO + 1) begin
      errors++; $display("FAIL timeout_when got err=%b after=%0d want err=1 after=%0d", err_timeout, n, TO + 1);
    end
    s0 = nsteps;
    for (int i = 0; i < 10; i++) begin @(negedge clk); stray |= read_enable | write_enable | k_step; end
    checks++;
    if (stray || nsteps != s0 || err_timeout !== 1'b1 || done !== 1'b0 || access_cnt !== 32'd0) begin
      errors++; $display("FAIL timeout_halt got stray=%b steps=%0d err=%b cnt=%0d want 0/0/1/0", stray, nsteps - s0, err_timeout, access_cnt);
    end
    start = 0;
  endtask

  task automatic test_reset_mid_wait;
    bit seen = 0;
    logic [2:0] first = '0;
    do_reset;
    hang = 1;
    read_base = 64'h500; read_size_input = 64'h8;
    push_exp(1'b0, 1'b1, 64'h510, '0);
    prog.push_back(mk(0, 0, 0, 0, 1, 0, 4, 0, 0));
    start = 1;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = read_enable; end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || read_addr !== 64'h510 || read_size_output !== 64'h8 || read_enable !== 1'b0) begin
      errors++; $display("FAIL wait1_hold got addr=%h size=%h en=%b want 510/8/0", read_addr, read_size_output, read_enable);
    end
    reset = 0;
    #1;
    checks++;
    if ({k_step, read_enable, write_enable, done, err_timeout} !== 5'b0 || read_addr !== '0 ||
        read_size_output !== '0 || access_cnt !== '0 || k_q1 !== '0) begin
      errors++; $display("FAIL mid_reset got addr=%h size=%h step=%b want all zero", read_addr, read_size_output, k_step);
    end
    repeat (2) @(negedge clk);
    prog.delete(); exp_q.delete();
    hang = 0;
    reset = 1;
    for (int i = 0; i < 20 && first == 3'b0; i++) begin
      @(negedge clk);
      first = {k_step, read_enable, write_enable};
    end
    checks++;
    if (first !== 3'b100) begin errors++; $display("FAIL first_after_reset got step/re/we=%b want=100", first); end
    start = 0;
  endtask

  initial begin
    test_reset;
    test_no_access;
    test_done_handshake;
    test_read_port0;
    test_dual;
    test_same_addr;
    test_back_to_back;
    test_timeout;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
